// File: rtl/run_step_ctrl.sv
// Run/stop/single-step controller producing a slow registered clock and reset for a processor top.
// Single-step support is compiled in only when STEP_MODE_EN is defined.

module run_step_deb #(
    parameter int DEB_W = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);
    logic             s1_q, s2_q;
    logic             lvl_q, lvl_d;
    logic             press_q, press_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    // Level is accepted only after the synchronized input differs from it for 2^DEB_W cycles.
    always_comb begin
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        press_d = 1'b0;
        if (s2_q == lvl_q) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            lvl_d   = s2_q;
            cnt_d   = '0;
            press_d = ~s2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            lvl_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            s1_q    <= btn_n;
            s2_q    <= s1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;
endmodule

module run_step_ctrl #(
    parameter int DIV_W = 22,
    parameter int DEB_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_run_n,
    input  logic        btn_step_n,
    input  logic        done,
    output logic        cpu_clk,
    output logic        cpu_reset,
    output logic [15:0] cycles,
    output logic        led_run_n,
    output logic        led_done_n
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRST = 3'd1,
        S_RUN  = 3'd2,
`ifdef STEP_MODE_EN
        S_STEP = 3'd3,
`endif
        S_HALT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic               cpu_clk_q, cpu_clk_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic [15:0]        cycles_q, cycles_d;
    logic               prst_cnt_q, prst_cnt_d;
    logic               to_halt_q, to_halt_d;
    logic               run_pend_q, run_pend_d;
    logic               done_s1_q, done_s2_q;
    logic [DIV_W-1:0]   div_q;
    logic               tick;
    logic               run_press;
    logic [15:0]        cycles_inc;

    run_step_deb #(.DEB_W(DEB_W)) u_run_deb (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_run_n),
        .press (run_press)
    );

`ifdef STEP_MODE_EN
    logic step_press;
    run_step_deb #(.DEB_W(DEB_W)) u_step_deb (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_step_n),
        .press (step_press)
    );
`else
    logic unused_step;
    assign unused_step = btn_step_n;
`endif

    assign tick       = &div_q;
    assign cycles_inc = (&cycles_q) ? cycles_q : cycles_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        cpu_clk_d   = cpu_clk_q;
        cpu_reset_d = cpu_reset_q;
        cycles_d    = cycles_q;
        prst_cnt_d  = prst_cnt_q;
        to_halt_d   = to_halt_q;
        run_pend_d  = run_pend_q;
        case (state_q)
            S_IDLE: begin
                cpu_reset_d = 1'b1;
                cpu_clk_d   = 1'b0;
                if (run_press) begin
                    state_d    = S_PRST;
                    prst_cnt_d = 1'b0;
                    to_halt_d  = 1'b0;
                    cycles_d   = '0;
`ifdef STEP_MODE_EN
                end else if (step_press) begin
                    state_d    = S_PRST;
                    prst_cnt_d = 1'b0;
                    to_halt_d  = 1'b1;
                    cycles_d   = '0;
`endif
                end
            end
            S_PRST: begin
                cycles_d = '0;
                if (tick) begin
                    if (prst_cnt_q) begin
                        state_d     = to_halt_q ? S_HALT : S_RUN;
                        cpu_reset_d = 1'b0;
                    end else begin
                        prst_cnt_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (run_press) run_pend_d = 1'b1;
                if (tick) begin
                    if (cpu_clk_q) begin
                        cpu_clk_d = 1'b0;
                    end else if (done_s2_q || run_pend_q || run_press) begin
                        // done wins over a simultaneous press; the press is dropped either way
                        state_d    = S_HALT;
                        run_pend_d = 1'b0;
                    end else begin
                        cpu_clk_d = 1'b1;
                        cycles_d  = cycles_inc;
                    end
                end
            end
`ifdef STEP_MODE_EN
            S_STEP: begin
                if (tick) begin
                    if (cpu_clk_q) begin
                        cpu_clk_d = 1'b0;
                        state_d   = S_HALT;
                    end else begin
                        cpu_clk_d = 1'b1;
                        cycles_d  = cycles_inc;
                    end
                end
            end
`endif
            S_HALT: begin
                if (run_press) begin
                    state_d     = S_PRST;
                    cpu_reset_d = 1'b1;
                    prst_cnt_d  = 1'b0;
                    to_halt_d   = 1'b0;
                    cycles_d    = '0;
`ifdef STEP_MODE_EN
                end else if (step_press) begin
                    state_d = S_STEP;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cpu_clk_q   <= 1'b0;
            cpu_reset_q <= 1'b1;
            cycles_q    <= '0;
            prst_cnt_q  <= 1'b0;
            to_halt_q   <= 1'b0;
            run_pend_q  <= 1'b0;
            done_s1_q   <= 1'b0;
            done_s2_q   <= 1'b0;
            div_q       <= '0;
        end else begin
            state_q     <= state_d;
            cpu_clk_q   <= cpu_clk_d;
            cpu_reset_q <= cpu_reset_d;
            cycles_q    <= cycles_d;
            prst_cnt_q  <= prst_cnt_d;
            to_halt_q   <= to_halt_d;
            run_pend_q  <= run_pend_d;
            done_s1_q   <= done;
            done_s2_q   <= done_s1_q;
            div_q       <= div_q + 1'b1;
        end
    end

    assign cpu_clk    = cpu_clk_q;
    assign cpu_reset  = cpu_reset_q;
    assign cycles     = cycles_q;
`ifdef STEP_MODE_EN
    assign led_run_n  = ~((state_q == S_RUN) || (state_q == S_STEP));
`else
    assign led_run_n  = ~(state_q == S_RUN);
`endif
    assign led_done_n = ~((state_q == S_HALT) && done_s2_q);
endmodule

// File: tb/tb_run_step_ctrl.sv
// Bench for run_step_ctrl with DIV_W=2, DEB_W=2; expected halt outcomes are queued when stimulus is applied.
module tb_run_step_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_run_n = 1'b1;
    logic        btn_step_n = 1'b1;
    logic        done = 1'b0;
    logic        cpu_clk, cpu_reset, led_run_n, led_done_n;
    logic [15:0] cycles;

    typedef struct {
        string      tag;
        bit         use_model;
        logic [15:0] cyc;
        logic       led_done;
    } exp_t;

    exp_t sb[$];
    int   cmp_cnt = 0;
    int   err_cnt = 0;
    int   rise_cnt = 0;
    int   cyc = 0;
    int   last_evt = -1;
    int   prst_start = -1;
    logic prev_clk = 1'b0, prev_rst = 1'b1, prev_led = 1'b1;

    run_step_ctrl #(.DIV_W(2), .DEB_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_run_n  (btn_run_n),
        .btn_step_n (btn_step_n),
        .done       (done),
        .cpu_clk    (cpu_clk),
        .cpu_reset  (cpu_reset),
        .cycles     (cycles),
        .led_run_n  (led_run_n),
        .led_done_n (led_done_n)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_halt(input string tag, input bit use_model, input logic [15:0] c, input logic ld);
        exp_t e;
        e.tag = tag; e.use_model = use_model; e.cyc = c; e.led_done = ld;
        sb.push_back(e);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return led_run_n;
            1:       return cpu_reset;
            2:       return cpu_clk;
            default: return (sb.size() == 0);
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic want, input int bound, input string tag);
        int n = 0;
        while (sig(sel) !== want && n < bound) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, sig(sel), want);
    endtask

    task automatic press_btn(input bit step);
        if (step) btn_step_n = 1'b0; else btn_run_n = 1'b0;
        repeat (8) @(negedge clk);
        btn_step_n = 1'b1;
        btn_run_n  = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Monitor: cpu_clk timing, cycles vs. counted rising edges, PRST length, halt scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                last_evt = -1;
                prst_start = -1;
                rise_cnt = 0;
            end else begin
                if (cpu_clk !== prev_clk) begin
                    if (last_evt >= 0) check_val("cpu_clk_half_period", cyc - last_evt, 4);
                    last_evt = cyc;
                    if (cpu_clk) begin
                        if (rise_cnt < 65535) rise_cnt++;
                        check_val("cycles_at_rise", {16'd0, cycles}, rise_cnt);
                    end
                end
                if (prev_rst && !cpu_reset) begin
                    last_evt = cyc;
                    if (prst_start >= 0)
                        check_val("prst_len_5_to_8", {31'd0, (cyc - prst_start >= 5) && (cyc - prst_start <= 8)}, 1);
                    prst_start = -1;
                end
                if (!prev_rst && cpu_reset) begin
                    prst_start = cyc;
                    check_val("prst_cycles_clear", {16'd0, cycles}, 0);
                end
                if (cpu_reset) rise_cnt = 0;
                if (!prev_led && led_run_n) begin
                    last_evt = -1;
                    if (sb.size() == 0) begin
                        check_val("halt_unexpected", sb.size(), 1);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check_val({e.tag, "_cycles"}, {16'd0, cycles}, e.use_model ? rise_cnt : {16'd0, e.cyc});
                        check_val({e.tag, "_led_done_n"}, led_done_n, e.led_done);
                        check_val({e.tag, "_cpu_clk"}, cpu_clk, 0);
                    end
                end
            end
            prev_clk = cpu_clk;
            prev_rst = cpu_reset;
            prev_led = led_run_n;
        end
    end

    initial begin
        int n;
        int c0;
        repeat (4) @(negedge clk);
        check_val("rst_cpu_clk", cpu_clk, 0);
        check_val("rst_cpu_reset", cpu_reset, 1);
        check_val("rst_led_run_n", led_run_n, 1);
        check_val("rst_led_done_n", led_done_n, 1);
        check_val("rst_cycles", {16'd0, cycles}, 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_val("idle_cpu_reset", cpu_reset, 1);
        check_val("idle_led_run_n", led_run_n, 1);

        // Run, then done after 10 cpu_clk rising edges
        press_btn(0);
        wait_for(0, 1'b0, 40, "enter_run");
        check_val("run_cpu_reset", cpu_reset, 0);
        n = 0;
        while (rise_cnt < 10 && n < 200) begin @(negedge clk); n++; end
        check_val("ten_rises", rise_cnt, 10);
        done = 1'b1;
        expect_halt("halt_done", 0, 16'd10, 1'b0);
        wait_for(0, 1'b1, 40, "halt_by_done");
        repeat (12) @(negedge clk);
        check_val("halt_hold_clk", cpu_clk, 0);
        check_val("halt_hold_cycles", {16'd0, cycles}, 10);
        check_val("halt_hold_led_done", led_done_n, 0);
        done = 1'b0;
        repeat (4) @(negedge clk);
        check_val("done_led_clear", led_done_n, 1);

        // Restart from HALT, glitch, then stop with a press
        press_btn(0);
        wait_for(0, 1'b0, 40, "rerun");
        n = 0;
        while (rise_cnt < 3 && n < 100) begin @(negedge clk); n++; end
        btn_run_n = 1'b0;
        repeat (2) @(negedge clk);
        btn_run_n = 1'b1;
        repeat (20) @(negedge clk);
        check_val("glitch_ignored", led_run_n, 0);
        expect_halt("halt_press", 1, 16'd0, 1'b1);
        press_btn(0);
        wait_for(0, 1'b1, 40, "halt_by_press");
        c0 = rise_cnt;
        repeat (16) @(negedge clk);
        check_val("press_hold_clk", cpu_clk, 0);
        check_val("press_hold_cycles", {16'd0, cycles}, c0);

`ifdef STEP_MODE_EN
        c0 = rise_cnt;
        for (int i = 1; i <= 3; i++) begin
            expect_halt("step", 0, 16'(c0 + i), 1'b1);
            press_btn(1);
            wait_for(3, 1'b1, 60, "step_done");
        end
        check_val("step_pulses", rise_cnt, c0 + 3);
        check_val("step_cycles", {16'd0, cycles}, c0 + 3);
        force dut.cycles_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.cycles_q;
        rise_cnt = 65534;
        for (int i = 0; i < 2; i++) begin
            expect_halt("step_sat", 0, 16'hFFFF, 1'b1);
            press_btn(1);
            wait_for(3, 1'b1, 60, "step_sat_done");
        end
        check_val("cycles_saturated", {16'd0, cycles}, 32'h0000_FFFF);
`else
        c0 = rise_cnt;
        press_btn(1);
        repeat (30) @(negedge clk);
        check_val("step_ignored_led", led_run_n, 1);
        check_val("step_ignored_cycles", {16'd0, cycles}, c0);
`endif

        // Reset while cpu_clk is high in RUN
        press_btn(0);
        wait_for(0, 1'b0, 40, "run_before_reset");
        wait_for(2, 1'b1, 40, "cpu_clk_high");
        #1 reset = 1'b1;
        #1;
        check_val("async_rst_cpu_clk", cpu_clk, 0);
        check_val("async_rst_cpu_reset", cpu_reset, 1);
        check_val("async_rst_led_run_n", led_run_n, 1);
        check_val("async_rst_cycles", {16'd0, cycles}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check_val("idle_after_reset", led_run_n, 1);
        check_val("idle_after_reset_rst", cpu_reset, 1);

`ifdef STEP_MODE_EN
        press_btn(1);
        wait_for(1, 1'b0, 40, "step_from_idle_prst");
        check_val("step_from_idle_halt", led_run_n, 1);
        check_val("step_from_idle_clk", cpu_clk, 0);
`endif

        check_val("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
